// File: rtl/bus_controller.sv
// Multicycle bus slave: one request -> one synchronous-RAM access plus WAIT_CYCLES wait states.
// Optional misaligned-address trap enabled by defining BUS_ALIGN_CHECK_EN.
module bus_controller #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_transaction,
  input  logic              mode,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              write_done,
  output logic              busy,
  output logic              bus_error,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_CAPTURE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            r_state;
  logic              r_mode;
  logic [3:0]        r_cnt;
  logic [31:0]       r_rdata;
  logic              r_rdata_valid;
  logic              r_write_done;
  logic              r_busy;
  logic              r_bus_error;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic w_misaligned;
  logic w_unused;

`ifdef BUS_ALIGN_CHECK_EN
  assign w_misaligned = |addr[1:0];
`else
  assign w_misaligned = 1'b0;
`endif

  // Byte-lane bits and bits above the RAM window never select a word.
  assign w_unused = ^{addr[31:ADDR_W+2], addr[1:0]};

  // Outputs are registered: each is set on the edge that enters the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_mode        <= 1'b0;
      r_cnt         <= 4'd0;
      r_rdata       <= 32'd0;
      r_rdata_valid <= 1'b0;
      r_write_done  <= 1'b0;
      r_busy        <= 1'b0;
      r_bus_error   <= 1'b0;
      r_mem_en      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= 32'd0;
    end else begin
      r_rdata_valid <= 1'b0;
      r_write_done  <= 1'b0;
      r_bus_error   <= 1'b0;
      r_mem_en      <= 1'b0;
      r_mem_we      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_transaction) begin
            r_mode      <= mode;
            r_mem_addr  <= addr[ADDR_W+1:2];
            r_mem_wdata <= wdata;
            r_busy      <= 1'b1;
            if (w_misaligned) begin
              r_state       <= S_RESP;
              r_rdata_valid <= ~mode;
              r_write_done  <= mode;
              r_bus_error   <= 1'b1;
            end else begin
              r_state  <= S_ACCESS;
              r_mem_en <= 1'b1;
              r_mem_we <= mode;
            end
          end
        end
        S_ACCESS: begin
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (!r_mode) begin
            r_rdata <= mem_rdata;
          end
          r_cnt <= WAIT_INIT;
          if (WAIT_INIT != 4'd0) begin
            r_state <= S_WAIT;
          end else begin
            r_state       <= S_RESP;
            r_rdata_valid <= ~r_mode;
            r_write_done  <= r_mode;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state       <= S_RESP;
            r_rdata_valid <= ~r_mode;
            r_write_done  <= r_mode;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign write_done  = r_write_done;
  assign busy        = r_busy;
  assign bus_error   = r_bus_error;
  assign mem_en      = r_mem_en;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_bus_controller.sv
// Bench for bus_controller: two instances (0 and 5 wait states) share one stimulus stream,
// each backed by its own RAM and checked every cycle against a transaction-level model.
module tb_bus_controller;

  localparam int AW = 10;
  localparam int W0 = 0;
  localparam int W1 = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode_i = 1'b0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] wdata_i = 32'd0;

  logic [31:0]   rdata     [2];
  logic [31:0]   mem_wdata [2];
  logic [31:0]   mem_rdata [2];
  logic [AW-1:0] mem_addr  [2];
  logic          rv [2];
  logic          wd [2];
  logic          busy [2];
  logic          be [2];
  logic          mem_en [2];
  logic          mem_we [2];

  logic [31:0] ram0 [1024];
  logic [31:0] ram1 [1024];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bus_controller #(.ADDR_W(AW), .WAIT_CYCLES(W0)) u_dut0 (
    .clk(clk), .rst(rst), .start_transaction(start), .mode(mode_i), .addr(addr_i),
    .wdata(wdata_i), .rdata(rdata[0]), .rdata_valid(rv[0]), .write_done(wd[0]),
    .busy(busy[0]), .bus_error(be[0]), .mem_en(mem_en[0]), .mem_we(mem_we[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  bus_controller #(.ADDR_W(AW), .WAIT_CYCLES(W1)) u_dut5 (
    .clk(clk), .rst(rst), .start_transaction(start), .mode(mode_i), .addr(addr_i),
    .wdata(wdata_i), .rdata(rdata[1]), .rdata_valid(rv[1]), .write_done(wd[1]),
    .busy(busy[1]), .bus_error(be[1]), .mem_en(mem_en[1]), .mem_we(mem_we[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  always @(posedge clk) begin
    if (mem_en[0]) begin
      if (mem_we[0]) ram0[mem_addr[0]] <= mem_wdata[0];
      else           mem_rdata[0] <= ram0[mem_addr[0]];
    end
  end

  always @(posedge clk) begin
    if (mem_en[1]) begin
      if (mem_we[1]) ram1[mem_addr[1]] <= mem_wdata[1];
      else           mem_rdata[1] <= ram1[mem_addr[1]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Transaction-level model: per instance, where in the current transaction we are.
  bit          act   [2];
  int          d     [2];
  bit          mis   [2];
  bit          m_mode[2];
  int          wa    [2];
  logic [31:0] m_wd  [2];
  logic [31:0] exp_rd[2] = '{32'd0, 32'd0};
  logic [31:0] mref  [2][1024];
  int          wc    [2] = '{W0, W1};

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        int len;
        bit fin;
        string p;
        p   = $sformatf("d%0d_", k);
        len = mis[k] ? 1 : 3 + wc[k];
        fin = act[k] && (d[k] == len);
        chk({p, "busy"}, 32'(busy[k]), 32'(act[k]));
        chk({p, "mem_en"}, 32'(mem_en[k]), 32'(act[k] && !mis[k] && d[k] == 1));
        if (act[k] && !mis[k] && d[k] == 1) chk({p, "mem_we"}, 32'(mem_we[k]), 32'(m_mode[k]));
        chk({p, "rdata_valid"}, 32'(rv[k]), 32'(fin && !m_mode[k]));
        chk({p, "write_done"}, 32'(wd[k]), 32'(fin && m_mode[k]));
        chk({p, "bus_error"}, 32'(be[k]), 32'(fin && mis[k]));
        chk({p, "rdata"}, rdata[k], exp_rd[k]);
        if (act[k]) begin
          chk({p, "mem_addr"}, 32'(mem_addr[k]), 32'(wa[k]));
          chk({p, "mem_wdata"}, mem_wdata[k], m_wd[k]);
        end
        // The RAM takes the write at the end of ACCESS even if reset arrives then.
        if (act[k] && !mis[k] && d[k] == 1 && m_mode[k]) mref[k][wa[k]] = m_wd[k];
        if (rst) begin
          act[k]    = 1'b0;
          exp_rd[k] = 32'd0;
        end else if (act[k]) begin
          if (d[k] == 2 && !mis[k] && !m_mode[k]) exp_rd[k] = mref[k][wa[k]];
          if (fin) act[k] = 1'b0;
          else d[k]++;
        end else if (start) begin
          act[k]    = 1'b1;
          d[k]      = 1;
          m_mode[k] = mode_i;
          wa[k]     = int'((addr_i >> 2) % (1 << AW));
          m_wd[k]   = wdata_i;
`ifdef BUS_ALIGN_CHECK_EN
          mis[k]    = (addr_i[1:0] != 2'b00);
`else
          mis[k]    = 1'b0;
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    #2;
    while ((busy[0] || busy[1]) && n < 60) begin
      tick();
      #2;
      n++;
    end
    chk("idle_bound", 32'(n < 60), 32'd1);
  endtask

  task automatic txn(input logic m, input logic [31:0] a, input logic [31:0] wdv);
    tick();
    start = 1'b1; mode_i = m; addr_i = a; wdata_i = wdv;
    tick();
    start = 1'b0;
    wait_idle();
  endtask

  initial begin
    int rv0_at, rv5_at, busy5_n, en0_n, rv0_n, en5_n, rv5_n;
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rv0_at, rv5_at, busy5_n, en0_n, rv0_n, en5_n, rv5_n;
    rst = 1'b1;
    repeat (3) tick();
    #2;
    chk("rst_rdata", rdata[0], 32'd0);
    chk("rst_busy", 32'(busy[1]), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr[0]), 32'd0);
    rst = 1'b0;

    // Write 0xDEADBEEF to 0x10 with cycle-level checks on the zero-wait instance.
    tick();
    start = 1'b1; mode_i = 1'b1; addr_i = 32'h10; wdata_i = 32'hDEADBEEF;
    tick();
    start = 1'b0;
    #2;
    chk("w_c1_mem_en", 32'(mem_en[0]), 32'd1);
    chk("w_c1_mem_addr", 32'(mem_addr[0]), 32'd4);
    tick(); #2;
    chk("w_c2_mem_en", 32'(mem_en[0]), 32'd0);
    tick(); #2;
    chk("w_c3_write_done", 32'(wd[0]), 32'd1);
    wait_idle();

    // Read 0x10: latency 3 vs 8, busy 8 cycles for the 5-wait instance.
    tick();
    start = 1'b1; mode_i = 1'b0; addr_i = 32'h10;
    rv0_at = -1; rv5_at = -1; busy5_n = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 1) start = 1'b0;
      #2;
      if (busy[1]) busy5_n++;
      if (rv[0]) rv0_at = i;
      if (rv[1]) rv5_at = i;
      if (i == 3) chk("r_c3_rdata", rdata[0], 32'hDEADBEEF);
    end
    chk("r_latency_w0", 32'(rv0_at), 32'd3);
    chk("r_latency_w5", 32'(rv5_at), 32'd8);
    chk("r_busy_cycles_w5", 32'(busy5_n), 32'd8);
    chk("r_rdata_w5", rdata[1], 32'hDEADBEEF);

    // Strobe held high C0..C3: exactly one access per instance.
    tick();
    start = 1'b1; mode_i = 1'b0; addr_i = 32'h10;
    en0_n = 0; rv0_n = 0; en5_n = 0; rv5_n = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 4) start = 1'b0;
      #2;
      if (mem_en[0]) en0_n++;
      if (rv[0]) rv0_n++;
      if (mem_en[1]) en5_n++;
      if (rv[1]) rv5_n++;
    end
    chk("hold_mem_en_w0", 32'(en0_n), 32'd1);
    chk("hold_rv_w0", 32'(rv0_n), 32'd1);
    chk("hold_mem_en_w5", 32'(en5_n), 32'd1);
    chk("hold_rv_w5", 32'(rv5_n), 32'd1);

    // Reset during CAPTURE of a read.
    tick();
    start = 1'b1; mode_i = 1'b0; addr_i = 32'h10;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    chk("rstmid_busy", 32'(busy[0]), 32'd0);
    chk("rstmid_rdata", rdata[0], 32'd0);
    chk("rstmid_rv", 32'(rv[0]), 32'd0);
    txn(1'b0, 32'h10, 32'd0);
    chk("rstmid_reread", rdata[0], 32'hDEADBEEF);

    // Reset and strobe in the same cycle: request dropped.
    tick();
    rst = 1'b1; start = 1'b1; mode_i = 1'b1; addr_i = 32'h20; wdata_i = 32'h55AA55AA;
    tick();
    rst = 1'b0; start = 1'b0;
    #2;
    chk("rststrobe_busy", 32'(busy[0]), 32'd0);
    chk("rststrobe_mem_en", 32'(mem_en[0]), 32'd0);

    // Misaligned write to 0x13.
    tick();
    start = 1'b1; mode_i = 1'b1; addr_i = 32'h13; wdata_i = 32'hCAFEF00D;
    tick();
    start = 1'b0;
    #2;
`ifdef BUS_ALIGN_CHECK_EN
    chk("mis_c1_mem_en", 32'(mem_en[0]), 32'd0);
    chk("mis_c1_write_done", 32'(wd[0]), 32'd1);
    chk("mis_c1_bus_error", 32'(be[0]), 32'd1);
`else
    chk("mis_c1_mem_en", 32'(mem_en[0]), 32'd1);
    chk("mis_c1_mem_addr", 32'(mem_addr[0]), 32'd4);
    chk("mis_c1_bus_error", 32'(be[0]), 32'd0);
`endif
    wait_idle();
    txn(1'b0, 32'h10, 32'd0);
`ifdef BUS_ALIGN_CHECK_EN
    chk("mis_readback", rdata[0], 32'hDEADBEEF);
`else
    chk("mis_readback", rdata[0], 32'hCAFEF00D);
`endif

    // Address wrap: byte 0x1000 is word 0 of a 1024-word RAM.
    txn(1'b1, 32'h1000, 32'h1234);
    txn(1'b0, 32'h0, 32'd0);
    chk("wrap_rdata_w0", rdata[0], 32'h1234);
    chk("wrap_rdata_w5", rdata[1], 32'h1234);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
